// File: rtl/seq_multiplier.sv
// Iterative shift-and-add multiplier: one width+1-bit adder, width iterations per product,
// start/done handshake, run-time signed or unsigned operands.
module seq_multiplier #(
    parameter int width = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [width-1:0]     m,
    input  logic [width-1:0]     q,
    output logic                 busy,
    output logic                 done,
    output logic [2*width-1:0]   mult
);

    localparam int CW = $clog2(width + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic [width-1:0]     r_m;
    logic [width-1:0]     r_q;
    logic [width-1:0]     r_upper;
    logic [CW-1:0]        r_cnt;
    logic                 r_neg;
    logic                 r_done;
    logic [2*width-1:0]   r_mult;

    logic [width-1:0]     w_m_abs;
    logic [width-1:0]     w_q_abs;
    logic [width:0]       w_addend;
    logic [width:0]       w_sum;
    logic [2*width-1:0]   w_prod;
    logic                 w_last;

    // The most negative operand negates to itself, which read as unsigned is its magnitude.
    assign w_m_abs  = (signed_mode && m[width-1]) ? -m : m;
    assign w_q_abs  = (signed_mode && q[width-1]) ? -q : q;

    assign w_addend = r_q[0] ? {1'b0, r_m} : '0;
    assign w_sum    = {1'b0, r_upper} + w_addend;
    // Product as it will stand after this iteration's right shift.
    assign w_prod   = {w_sum, r_q[width-1:1]};
    assign w_last   = (r_state == CALC) && (r_cnt == CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: default first, so no path leaves w_next_state unassigned and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start)  w_next_state = CALC;
            CALC:    if (w_last) w_next_state = IDLE;
            default:             w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m     <= '0;
            r_q     <= '0;
            r_upper <= '0;
            r_cnt   <= '0;
            r_neg   <= 1'b0;
            r_done  <= 1'b0;
            r_mult  <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_m     <= w_m_abs;
                        r_q     <= w_q_abs;
                        r_neg   <= signed_mode & (m[width-1] ^ q[width-1]);
                        r_upper <= '0;
                        r_cnt   <= CW'(width);
                    end
                end
                CALC: begin
                    r_upper <= w_sum[width:1];
                    r_q     <= {w_sum[0], r_q[width-1:1]};
                    r_cnt   <= r_cnt - CW'(1);
                    if (w_last) begin
                        r_mult <= r_neg ? -w_prod : w_prod;
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == CALC);
    assign done = r_done;
    assign mult = r_mult;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative shift-and-add multiplier with a start/done handshake, parametrised width and run-time selectable signed or unsigned operation. It replaces the combinational array multiplier in datapaths where area matters more than latency, trading one result per `width+1` cycles for a single adder of `width+1` bits. It sits in the Datapath/Multiplier group and feeds the ALU result mux.

## Interface
- `width`, default 8: operand width in bits. Legal values are ≥ 2. The product is `2*width` bits.
- `clk`  input  1: clock, rising-edge active.
- `rst`  input  1: asynchronous reset, active-high.
- `start`  input  1: request a multiply. Sampled only in IDLE.
- `signed_mode`  input  1: 1 = two's-complement operands; 0 = unsigned. Sampled together with `start`.
- `m`  input  `width`: multiplicand. Sampled together with `start`.
- `q`  input  `width`: multiplier. Sampled together with `start`.
- `busy`  output  1: high while an operation is in progress.
- `done`  output  1: one-cycle pulse when `mult` updates.
- `mult`  output  `2*width`: registered product. Holds the last result.

## Operation
- States:
  - IDLE: `busy`=0.
  - CALC: `busy`=1, with an iteration counter of `$clog2(width+1)` bits.
- IDLE → CALC on a clock edge with `start`=1. At that edge:
  - `m_reg` ← |m| and `q_reg` ← |q| when `signed_mode`=1 and the operand MSB is 1; otherwise the operands are stored raw.
  - |−2^(width−1)| = 2^(width−1) is stored as an unsigned `width`-bit value. No overflow occurs.
  - `neg` ← `signed_mode` & (m[MSB] ^ q[MSB]).
  - The accumulator (upper half plus carry bit) is cleared, and counter ← `width`.
- Each CALC edge:
  - If `q_reg[0]`, then {carry, upper} ← upper + `m_reg` (`width+1`-bit sum).
  - {carry, upper, q_reg} is then shifted right by one.
  - The counter decrements by one.
- On the CALC edge where the counter goes from 1 to 0:
  - `mult` ← `neg` ? −P : P, where P is the final `2*width`-bit magnitude and negation is two's complement modulo 2^(2*width).
  - `done` ← 1 for exactly one cycle, and the state returns to IDLE.
- `start` while `busy`=1 is ignored. Operands are not re-sampled and no queueing occurs.
- `mult` is not cleared at `start`. It changes only at completion or reset.
- Zero operands do not shorten the operation. All `width` iterations always run.
- Arithmetic results:
  - Unsigned: exact product, range 0..(2^width−1)^2.
  - Signed: exact product, range −2^(2*width−2)+2^(width−1) .. 2^(2*width−2).
- Reset (`rst`=1, at any time, asynchronous): state IDLE, `busy`=0, `done`=0, `mult`=0, internal registers 0.
  - Reset mid-operation aborts the operation. No `done` is produced.
  - A fresh `start` is required after `rst` deasserts.

## Timing
- Let E0 be the edge that samples `start`=1 in IDLE.
- `busy` goes high after E0 and stays high through the cycle before E`width`.
- At E`width`: `mult` is valid, `done`=1 for the cycle following E`width`, and `busy`=0.
- Latency is `width` clocks from the start edge to valid `mult`/`done`.
- A `start` present during the `done` cycle is accepted at E`width+1`. Maximum throughput is therefore one product per `width+1` clocks.
- Outputs are fully registered. There is no combinational path from inputs to outputs.

## Test plan
- `width`=8, unsigned, m=0x05, q=0x06 → `done` exactly 8 edges after the start edge, `mult`=0x001E; `busy` high for exactly 8 cycles.
- Unsigned m=0xFF, q=0xFF → 0xFE01. Signed m=0xFF, q=0xFF (−1·−1) → 0x0001.
- Signed corner cases:
  - m=0x80, q=0x80 → 0x4000.
  - m=0x80, q=0x01 → 0xFF80.
  - m=0x7F, q=0x80 → 0xC080.
- Back-to-back: assert `start` with 0xAA×0xFF (unsigned) during the `done` cycle of a previous op → accepted, result 0xA956. Pulse `start` with other operands mid-CALC → ignored, result unchanged.
- Assert `rst` asynchronously at iteration 4 of 0xA0×0xFF → `busy`, `done`, `mult` are 0 immediately, and no `done` pulse follows. A new start of 0x0F×0x0D yields 0x00C3.
- Parameter sweep `width`=2, 4, 16: random signed and unsigned operands checked against the behavioural `*`; `done` latency equals `width` in every case.
